spi_ram_ctrl: RTL and testbench

- Command-decoding single-port RAM stage sitting directly downstream of the SPI slave.
- Consumes the slave's 10-bit rx_data/rx_valid words. Decodes rx_data[9:8] into write-address, write-data, read-address and read-data commands.
- Returns read bytes to the slave on tx_data/tx_valid, held stable for the full 8-bit serial shift-out.
- Together with the slave it forms the SPI-to-RAM wrapper.

---
 rtl/spi_ram_ctrl.sv | 137 +++++++++++++
 tb/tb_spi_ram_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command-decoding single-port RAM stage behind an SPI slave.
// Decodes 10-bit command words (opcode in [9:8], payload in [7:0]) into
// write-address, write-data, read-address and read-data commands, and returns
// read bytes on tx_data/tx_valid held for TX_HOLD cycles.
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   rx_data   command word from SPI slave
//   rx_valid  command-word valid (level; only its rising edge is accepted)
//   tx_data   read byte to SPI slave
//   tx_valid  tx_data valid, high TX_HOLD cycles per read
//   busy      high while a read is being fetched or held
//   tx_drop   one-cycle pulse when a read-data command is ignored
module spi_ram_ctrl #(
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned TX_HOLD   = 8,
  parameter int unsigned AUTO_INC  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       busy,
  output logic       tx_drop
);

  localparam int unsigned DEPTH = 1 << ADDR_SIZE;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_FETCH = 2'd1,
    S_TX_HOLD  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [7:0]           mem [DEPTH];
  logic [7:0]           fetch;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [CNT_W-1:0]     hold_cnt;
  logic                 rx_valid_d;
  logic                 rx_armed;

  logic                 accept_c;
  logic                 start_rd_c;
  logic                 drop_rd_c;
  logic [1:0]           opcode_c;
  logic [ADDR_SIZE-1:0] payload_c;

  // Command decode; rx_armed blocks a level that was already high through reset
  always_comb begin
    opcode_c   = rx_data[9:8];
    payload_c  = rx_data[ADDR_SIZE-1:0];
    accept_c   = rx_valid & ~rx_valid_d & rx_armed & ~rst;
    start_rd_c = accept_c && (opcode_c == OP_RD_DATA) && (state == S_IDLE);
    drop_rd_c  = accept_c && (opcode_c == OP_RD_DATA) && (state != S_IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start_rd_c) state_nxt = S_RD_FETCH;
      S_RD_FETCH: state_nxt = S_TX_HOLD;
      S_TX_HOLD:  if (hold_cnt == '0) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    busy = (state != S_IDLE);
  end

  // Memory array and fetch register; contents are not reset
  always_ff @(posedge clk) begin
    if (accept_c && (opcode_c == OP_WR_DATA)) mem[wr_addr] <= rx_data[7:0];
    if (start_rd_c) fetch <= mem[rd_addr];
  end

  // Address registers, edge detect, hold counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      tx_drop    <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      hold_cnt   <= '0;
      rx_valid_d <= 1'b0;
      rx_armed   <= ~rx_valid;
    end else begin
      rx_valid_d <= rx_valid;
      if (!rx_valid) rx_armed <= 1'b1;
      tx_drop <= drop_rd_c;

      if (accept_c) begin
        case (opcode_c)
          OP_WR_ADDR: wr_addr <= payload_c;
          OP_WR_DATA: if (AUTO_INC != 0) wr_addr <= wr_addr + ADDR_SIZE'(1);
          OP_RD_ADDR: rd_addr <= payload_c;
          default: ;
        endcase
      end

      case (state)
        S_RD_FETCH: begin
          tx_data  <= fetch;
          tx_valid <= 1'b1;
          hold_cnt <= CNT_W'(TX_HOLD - 1);
        end
        S_TX_HOLD: begin
          if (hold_cnt == '0) tx_valid <= 1'b0;
          else                hold_cnt <= hold_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: instance a uses defaults (AUTO_INC=0),
// instance b has AUTO_INC=1; both see the same command stream.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] a_tx_data, b_tx_data;
  logic       a_tx_valid, b_tx_valid;
  logic       a_busy, b_busy;
  logic       a_tx_drop, b_tx_drop;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.ADDR_SIZE(8), .TX_HOLD(8), .AUTO_INC(0)) u_a (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .busy(a_busy), .tx_drop(a_tx_drop)
  );

  spi_ram_ctrl #(.ADDR_SIZE(8), .TX_HOLD(8), .AUTO_INC(1)) u_b (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .busy(b_busy), .tx_drop(b_tx_drop)
  );

  typedef struct {
    logic [9:0] word;
    bit         chk_a;
    logic [7:0] exp_a;
    bit         chk_b;
    logic [7:0] exp_b;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse one command word; called and returns at a negedge (just after the accept edge)
  task automatic issue(input logic [9:0] w);
    rx_data  = w;
    rx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Check the 15 cycles after a read accept; k counts negedges after the accept edge.
  // Optionally injects a second command word at negedge inj_k.
  task automatic check_read(input string tag, input bit ca, input logic [7:0] ea,
                            input bit cb, input logic [7:0] eb,
                            input int inj_k, input logic [9:0] inj_w, input int exp_drops);
    int  drops_a = 0;
    int  drops_b = 0;
    bit  exp_v;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) @(negedge clk);
      exp_v = (k >= 1) && (k <= 8);
      check($sformatf("%s a_valid k=%0d", tag, k), 32'(a_tx_valid), 32'(exp_v));
      check($sformatf("%s b_valid k=%0d", tag, k), 32'(b_tx_valid), 32'(exp_v));
      check($sformatf("%s a_busy k=%0d", tag, k), 32'(a_busy), 32'(k <= 8));
      check($sformatf("%s b_busy k=%0d", tag, k), 32'(b_busy), 32'(k <= 8));
      if (k >= 1 && ca) check($sformatf("%s a_data k=%0d", tag, k), 32'(a_tx_data), 32'(ea));
      if (k >= 1 && cb) check($sformatf("%s b_data k=%0d", tag, k), 32'(b_tx_data), 32'(eb));
      drops_a += int'(a_tx_drop);
      drops_b += int'(b_tx_drop);
      if (k == inj_k) begin
        rx_data  = inj_w;
        rx_valid = 1'b1;
      end
      if (k == inj_k + 1) rx_valid = 1'b0;
    end
    check($sformatf("%s a_drops", tag), 32'(drops_a), 32'(exp_drops));
    check($sformatf("%s b_drops", tag), 32'(drops_b), 32'(exp_drops));
  endtask

  initial begin
    // Wrap with AUTO_INC: a overwrites 0xFF, b advances to 0x00
    tbl.push_back('{10'h0FF, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h111, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h122, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h2FF, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h300, 1'b1, 8'h22, 1'b1, 8'h11});
    tbl.push_back('{10'h200, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h300, 1'b0, 8'h00, 1'b1, 8'h22});
    // Write then read back
    tbl.push_back('{10'h012, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h1A5, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h212, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h300, 1'b1, 8'hA5, 1'b1, 8'hA5});
    // Further patterns
    tbl.push_back('{10'h005, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h133, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h034, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h15A, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h205, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h300, 1'b1, 8'h33, 1'b1, 8'h33});
    tbl.push_back('{10'h234, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h300, 1'b1, 8'h5A, 1'b1, 8'h5A});
    tbl.push_back('{10'h080, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h1C3, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h280, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{10'h300, 1'b1, 8'hC3, 1'b1, 8'hC3});

    // Reset values
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (2) @(negedge clk);
    check("rst a_tx_data", 32'(a_tx_data), 32'h0);
    check("rst a_tx_valid", 32'(a_tx_valid), 32'h0);
    check("rst a_busy", 32'(a_busy), 32'h0);
    check("rst a_tx_drop", 32'(a_tx_drop), 32'h0);
    check("rst b_busy", 32'(b_busy), 32'h0);

    // rx_valid already high when reset deasserts must not be accepted
    rx_data  = 10'h300;
    rx_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("held_through_rst a_busy c%0d", i), 32'(a_busy), 32'h0);
      check($sformatf("held_through_rst b_busy c%0d", i), 32'(b_busy), 32'h0);
    end
    rx_valid = 1'b0;
    @(negedge clk);

    // Table-driven command stream
    for (int i = 0; i < tbl.size(); i++) begin
      issue(tbl[i].word);
      if (tbl[i].word[9:8] == 2'b11)
        check_read($sformatf("vec%0d", i), tbl[i].chk_a, tbl[i].exp_a,
                   tbl[i].chk_b, tbl[i].exp_b, -1, 10'h000, 0);
      else
        @(negedge clk);
    end

    // Level-held rx_valid: b (AUTO_INC) would advance wr_addr on any re-trigger
    issue(10'h040); @(negedge clk);
    rx_data  = 10'h1FF;
    rx_valid = 1'b1;
    repeat (20) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    issue(10'h1EE); @(negedge clk);
    issue(10'h240); @(negedge clk);
    issue(10'h300);
    check_read("level_40", 1'b1, 8'hEE, 1'b1, 8'hFF, -1, 10'h000, 0);
    issue(10'h241); @(negedge clk);
    issue(10'h300);
    check_read("level_41", 1'b0, 8'h00, 1'b1, 8'hEE, -1, 10'h000, 0);

    // Level-held with data changing after the first cycle: only 0xFF may land
    issue(10'h050); @(negedge clk);
    rx_data  = 10'h1FF;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_data  = 10'h1C3;
    repeat (19) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    issue(10'h250); @(negedge clk);
    issue(10'h300);
    check_read("level_50", 1'b1, 8'hFF, 1'b1, 8'hFF, -1, 10'h000, 0);

    // Read overrun: second read-data edge during TX_HOLD is dropped
    issue(10'h212); @(negedge clk);
    issue(10'h300);
    check_read("overrun", 1'b1, 8'hA5, 1'b1, 8'hA5, 2, 10'h3AB, 1);

    // Write to the address being transmitted does not disturb the held byte
    issue(10'h005); @(negedge clk);
    issue(10'h133); @(negedge clk);
    issue(10'h205); @(negedge clk);
    issue(10'h300);
    check_read("wr_during_rd", 1'b1, 8'h33, 1'b1, 8'h33, 3, 10'h177, 0);
    issue(10'h300);
    check_read("after_wr", 1'b1, 8'h77, 1'b1, 8'h33, -1, 10'h000, 0);

    // Reset on the 3rd tx_valid cycle
    issue(10'h300);
    repeat (3) @(negedge clk);
    check("midrd a_tx_valid pre", 32'(a_tx_valid), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("midrd a_tx_valid", 32'(a_tx_valid), 32'h0);
    check("midrd a_busy", 32'(a_busy), 32'h0);
    check("midrd b_tx_valid", 32'(b_tx_valid), 32'h0);
    check("midrd b_busy", 32'(b_busy), 32'h0);
    check("midrd a_tx_data", 32'(a_tx_data), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    issue(10'h212); @(negedge clk);
    issue(10'h300);
    check_read("post_rst_12", 1'b1, 8'hA5, 1'b1, 8'hA5, -1, 10'h000, 0);
    issue(10'h205); @(negedge clk);
    issue(10'h300);
    check_read("post_rst_05", 1'b1, 8'h77, 1'b1, 8'h33, -1, 10'h000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
